// File: rtl/reel_rng_bank_if.sv
// Purpose: bundles the reel bank's range/spin/stop inputs and its value/status outputs.
// Latency: none; plain wires between the control FSM, the bank and the payout logic.
// Backpressure: none; spin/stop are level requests sampled on the bank's clock.
interface reel_rng_bank_if #(
  parameter int N = 3,
  parameter int W = 4
);
  logic [W-1:0]   min;
  logic [W-1:0]   max;
  logic           spin;
  logic [N-1:0]   stop;
  logic [N*W-1:0] value;
  logic [N-1:0]   spinning;
  logic [N-1:0]   locked;
  logic           done;
  logic           match;

  modport master (
    output min, max, spin, stop,
    input  value, spinning, locked, done, match
  );

  modport slave (
    input  min, max, spin, stop,
    output value, spinning, locked, done, match
  );
endinterface

// File: rtl/reel_rng_bank.sv
// Purpose: N reel counters sharing one [min,max] range, each with stride i+1 and a spin/stop/lock FSM.
// Latency: one clock from spin/stop sample to state change; done and match are registered on the last-lock edge.
// Backpressure: none; spin is dropped while any reel spins, stop is dropped for reels that are not spinning.
module reel_rng_bank #(
  parameter int N       = 3,
  parameter int W       = 4,
  parameter int TIMEOUT = 0
) (
  input  logic           clk,
  input  logic           rst,
  reel_rng_bank_if.slave bus
);

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SPIN   = 2'd1,
    S_LOCKED = 2'd2
  } state_e;

  state_e [N-1:0]         state_q, state_d;
  logic   [N-1:0][W-1:0]  value_q, value_d;
  logic   [N-1:0][CW-1:0] cnt_q, cnt_d;
  logic                   done_q, done_d;
  logic                   match_q, match_d;
  logic                   any_spin_q, any_spin_d;
  logic                   accept;
  logic                   all_eq;

  // Next value of a reel: wraps to min when the stride would pass max, parks at min for an empty range.
  function automatic logic [W-1:0] step_val(
    input logic [W-1:0] cur,
    input logic [W-1:0] lo,
    input logic [W-1:0] hi,
    input logic [W:0]   stride
  );
    logic [W:0] sum;
    sum = {1'b0, cur} + stride;
    if (lo > hi) begin
      return lo;
    end
    if ((cur < lo) || (sum > {1'b0, hi})) begin
      return lo;
    end
    return sum[W-1:0];
  endfunction

  // Per-reel next state, value and timeout count, plus the bank-level done/match decisions.
  always_comb begin
    state_d    = state_q;
    value_d    = value_q;
    cnt_d      = cnt_q;
    any_spin_q = 1'b0;
    any_spin_d = 1'b0;
    all_eq     = 1'b1;

    for (int i = 0; i < N; i++) begin
      if (state_q[i] == S_SPIN) begin
        any_spin_q = 1'b1;
      end
    end

    // A new spin only starts once every reel has come to rest.
    accept = bus.spin && !any_spin_q;

    for (int i = 0; i < N; i++) begin
      if (accept) begin
        // Spin beats a simultaneous stop; the value carries over into the new spin.
        state_d[i] = S_SPIN;
        cnt_d[i]   = '0;
      end else if (state_q[i] == S_SPIN) begin
        if (bus.stop[i] || ((TIMEOUT != 0) && (cnt_q[i] == CNT_LAST))) begin
          // Lock freezes the value the player saw when pressing stop.
          state_d[i] = S_LOCKED;
        end else begin
          value_d[i] = step_val(value_q[i], bus.min, bus.max, (W+1)'(i + 1));
          cnt_d[i]   = cnt_q[i] + 1'b1;
        end
      end
    end

    for (int i = 0; i < N; i++) begin
      if (state_d[i] == S_SPIN) begin
        any_spin_d = 1'b1;
      end
      if (value_d[i] != value_d[0]) begin
        all_eq = 1'b0;
      end
    end

    // Several reels locking on one edge still produce a single done.
    done_d  = any_spin_q && !any_spin_d;
    match_d = match_q;
    if (accept) begin
      match_d = 1'b0;
    end else if (done_d) begin
      match_d = all_eq;
    end
  end

  // State, value and counter registers; reset clears everything without waiting for a clock.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= {N{S_IDLE}};
      value_q <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      match_q <= 1'b0;
    end else begin
      state_q <= state_d;
      value_q <= value_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      match_q <= match_d;
    end
  end

  // Status decode straight from the registered reel states.
  always_comb begin
    bus.spinning = '0;
    bus.locked   = '0;
    for (int i = 0; i < N; i++) begin
      bus.spinning[i] = (state_q[i] == S_SPIN);
      bus.locked[i]   = (state_q[i] == S_LOCKED);
    end
  end

  assign bus.value = value_q;
  assign bus.done  = done_q;
  assign bus.match = match_q;

endmodule
